// File: rtl/ex_div_pkg.sv
// Shared RV32M divide encodings: func3 codes, func7 and sequencer states.
// Imported by the divide sequencer and its datapath step.
package ex_div_pkg;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;
    localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_START = 2'd1,
        DIV_CALC  = 2'd2,
        DIV_END   = 2'd3
    } div_state_e;

    function automatic logic is_signed_op(input logic [2:0] func3);
        return (func3 == INST_DIV) || (func3 == INST_REM);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, subtract when it fits.
// Purely combinational, zero latency, no flow control.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            bit_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0] shifted;

    // The partial remainder is always below the divisor, so the XLEN-bit
    // difference is exact whenever the extra-bit compare says it fits.
    assign shifted = {rem_i, bit_i};
    assign q_bit_o = (shifted >= {1'b0, divisor_i});
    assign rem_o   = q_bit_o ? (shifted[XLEN-1:0] - divisor_i) : shifted[XLEN-1:0];

endmodule

// File: rtl/ex_div.sv
// RV32M DIV/DIVU/REM/REMU sequencer: 35 edges start-to-ready (3 on divide by zero).
// Holds the pipeline via hold_o while busy; flush_i cancels without writing back.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic            ready_o,
    output logic [4:0]      rd_addr_o,
    output logic            busy_o,
    output logic            hold_o
);

    div_state_e      state_q, state_d;
    logic [2:0]      func3_q, func3_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            ready_q, ready_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic            busy_q, busy_d;

    logic [XLEN-1:0] step_rem;
    logic            step_q_bit;
    logic            signed_op;
    logic [XLEN-1:0] quot_fix, rem_fix;

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i    (rem_q),
        .divisor_i(dvs_q),
        .bit_i    (dvd_q[XLEN-1]),
        .rem_o    (step_rem),
        .q_bit_o  (step_q_bit)
    );

    assign signed_op = is_signed_op(func3_q);
    assign quot_fix  = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
    assign rem_fix   = neg_rem_q  ? (~rem_q + 1'b1)  : rem_q;

    always_comb begin
        state_d    = state_q;
        func3_d    = func3_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rd_d       = rd_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = 1'b0;
        rd_out_d   = rd_out_q;

        case (state_q)
            DIV_IDLE: begin
                if (start_i && !flush_i) begin
                    func3_d = func3_i;
                    dvd_d   = dividend_i;
                    dvs_d   = divisor_i;
                    rd_d    = rd_addr_i;
                    state_d = DIV_START;
                end
            end
            DIV_START: begin
                if (dvs_q == '0) begin
                    // Divide by zero skips the sign fix: all-ones quotient, raw dividend.
                    quot_d     = '1;
                    rem_d      = dvd_q;
                    neg_quot_d = 1'b0;
                    neg_rem_d  = 1'b0;
                    state_d    = DIV_END;
                end else begin
                    dvd_d      = (signed_op && dvd_q[XLEN-1]) ? (~dvd_q + 1'b1) : dvd_q;
                    dvs_d      = (signed_op && dvs_q[XLEN-1]) ? (~dvs_q + 1'b1) : dvs_q;
                    neg_quot_d = signed_op && (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
                    neg_rem_d  = signed_op && dvd_q[XLEN-1];
                    quot_d     = '0;
                    rem_d      = '0;
                    cnt_d      = '0;
                    state_d    = DIV_CALC;
                end
            end
            DIV_CALC: begin
                rem_d  = step_rem;
                quot_d = {quot_q[XLEN-2:0], step_q_bit};
                dvd_d  = {dvd_q[XLEN-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = DIV_END;
                end
            end
            DIV_END: begin
                result_d = func3_q[1] ? rem_fix : quot_fix;
                rd_out_d = rd_q;
                ready_d  = 1'b1;
                state_d  = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase

        if (flush_i && (state_q != DIV_IDLE)) begin
            state_d  = DIV_IDLE;
            ready_d  = 1'b0;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    assign busy_d = (state_d != DIV_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DIV_IDLE;
            func3_q    <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rd_q       <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
            rd_out_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            func3_q    <= func3_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rd_q       <= rd_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
            rd_out_q   <= rd_out_d;
            busy_q     <= busy_d;
        end
    end

    assign result_o  = result_q;
    assign ready_o   = ready_q;
    assign rd_addr_o = rd_out_q;
    assign busy_o    = busy_q;
    assign hold_o    = (start_i && !flush_i && (state_q == DIV_IDLE)) || (state_q != DIV_IDLE);

endmodule

// File: tb/tb_ex_div.sv
// Directed-vector bench for ex_div: results, latency, hold/busy, flush and async reset.
module tb_ex_div;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  func3_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic [4:0]  rd_addr_o;
    logic        busy_o;
    logic        hold_o;

    int checks = 0;
    int errors = 0;

    ex_div #(.XLEN(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .func3_i   (func3_i),
        .dividend_i(dividend_i),
        .divisor_i (divisor_i),
        .rd_addr_i (rd_addr_i),
        .flush_i   (flush_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .rd_addr_o (rd_addr_o),
        .busy_o    (busy_o),
        .hold_o    (hold_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Issues one operation and returns at the negedge where ready_o is seen.
    // lat counts clock edges after the accepting edge; -1 means no completion.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          output int lat, output logic [31:0] res, output logic [4:0] rdo);
        @(negedge clk);
        func3_i    = f;
        dividend_i = a;
        divisor_i  = b;
        rd_addr_i  = rd;
        start_i    = 1'b1;
        #1;
        check({tag, "_hold_req"}, 32'(hold_o), 32'd1);
        @(posedge clk);
        #1 start_i = 1'b0;
        lat = -1;
        res = '0;
        rdo = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (ready_o) begin
                lat = k - 1;
                res = result_o;
                rdo = rd_addr_o;
                break;
            end
        end
    endtask

    int          lat;
    logic [31:0] res;
    logic [4:0]  rdo;
    int          pulses;

    initial begin
        rst_n      = 1'b0;
        start_i    = 1'b0;
        func3_i    = 3'b000;
        dividend_i = '0;
        divisor_i  = '0;
        rd_addr_i  = '0;
        flush_i    = 1'b0;
        #12;
        check("rst_result", result_o, 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_rd", 32'(rd_addr_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_hold", 32'(hold_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // DIVU 100/7 with full latency and handshake checks
        run_op("divu100_7", 3'b101, 32'd100, 32'd7, 5'd5, lat, res, rdo);
        check("divu100_7_lat", 32'(lat), 32'd34);
        check("divu100_7_res", res, 32'd14);
        check("divu100_7_rd", 32'(rdo), 32'd5);
        check("divu100_7_hold_rdy", 32'(hold_o), 32'd0);
        @(negedge clk);
        check("divu100_7_pulse", 32'(ready_o), 32'd0);
        check("divu100_7_keep", result_o, 32'd14);

        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd1, lat, res, rdo);
        check("rem_m7_2_res", res, 32'hFFFF_FFFF);
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd2, lat, res, rdo);
        check("div_m7_2_res", res, 32'hFFFF_FFFD);
        run_op("remu_f9_2", 3'b111, 32'hFFFF_FFF9, 32'd2, 5'd3, lat, res, rdo);
        check("remu_f9_2_res", res, 32'd1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, lat, res, rdo);
        check("div_ovf_res", res, 32'h8000_0000);
        check("div_ovf_lat", 32'(lat), 32'd34);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, lat, res, rdo);
        check("rem_ovf_res", res, 32'd0);

        run_op("divu_by0", 3'b101, 32'd123, 32'd0, 5'd7, lat, res, rdo);
        check("divu_by0_res", res, 32'hFFFF_FFFF);
        check("divu_by0_lat", 32'(lat), 32'd2);
        run_op("rem_by0", 3'b110, 32'd123, 32'd0, 5'd8, lat, res, rdo);
        check("rem_by0_res", res, 32'd123);
        check("rem_by0_lat", 32'(lat), 32'd2);
        check("rem_by0_rd", 32'(rdo), 32'd8);

        // Flush at CALC count 10: no write-back, old result retained
        @(negedge clk);
        func3_i = 3'b101; dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd9;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (2) @(negedge clk);
        check("flush_busy_before", 32'(busy_o), 32'd1);
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        check("flush_busy_after", 32'(busy_o), 32'd0);
        check("flush_hold_after", 32'(hold_o), 32'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready_o) pulses++;
        end
        check("flush_no_ready", 32'(pulses), 32'd0);
        check("flush_result_kept", result_o, 32'd123);
        check("flush_rd_kept", 32'(rd_addr_o), 32'd8);

        // Flush together with start in IDLE: nothing accepted
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1;
        #1 check("flush_start_hold", 32'(hold_o), 32'd0);
        @(posedge clk);
        #1 begin start_i = 1'b0; flush_i = 1'b0; end
        @(negedge clk);
        check("flush_start_busy", 32'(busy_o), 32'd0);

        // Second start mid-operation is ignored
        @(negedge clk);
        func3_i = 3'b101; dividend_i = 32'd50; divisor_i = 32'd5; rd_addr_i = 5'd3;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (5) @(negedge clk);
        func3_i = 3'b101; dividend_i = 32'd77; divisor_i = 32'd7; rd_addr_i = 5'd11;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (ready_o) begin
                pulses++;
                res = result_o;
                rdo = rd_addr_o;
            end
        end
        check("restart_pulses", 32'(pulses), 32'd1);
        check("restart_res", res, 32'd10);
        check("restart_rd", 32'(rdo), 32'd3);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        func3_i = 3'b101; dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd12;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_result", result_o, 32'd0);
        check("arst_rd", 32'(rd_addr_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_hold", 32'(hold_o), 32'd0);
        check("arst_ready", 32'(ready_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("divu9_3", 3'b101, 32'd9, 32'd3, 5'd13, lat, res, rdo);
        check("divu9_3_res", res, 32'd3);
        check("divu9_3_lat", 32'(lat), 32'd34);
        check("divu9_3_rd", 32'(rdo), 32'd13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
